// File: rtl/cr_lsu_pkg.sv
// Shared types and constants for the multi-outstanding LSU request controller.
// Exception vectors, occupancy state encodings and the per-entry tracking record.
package cr_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FULL   = 2'd2
    } lsu_state_e;

    typedef struct packed {
        logic vld;
        logic store;
        logic fast;
        logic kill;
    } lsu_entry_t;

    localparam logic [4:0] EXPT_MISL = 5'b00100;
    localparam logic [4:0] EXPT_MISS = 5'b00110;
    localparam logic [4:0] EXPT_ACCL = 5'b00101;
    localparam logic [4:0] EXPT_ACCS = 5'b00111;

endpackage

// File: rtl/cr_lsu_ctrl_mo_if.sv
// LSU <-> BMU data-bus handshake; master is the LSU side, slave the bus side.
interface cr_lsu_ctrl_mo_if;
    logic lsu_bmu_req;
    logic bmu_lsu_grnt;
    logic bmu_lsu_trans_cmplt;
    logic bmu_lsu_data_vld;
    logic bmu_lsu_acc_err;

    modport master (
        output lsu_bmu_req,
        input  bmu_lsu_grnt,
        input  bmu_lsu_trans_cmplt,
        input  bmu_lsu_data_vld,
        input  bmu_lsu_acc_err
    );

    modport slave (
        input  lsu_bmu_req,
        output bmu_lsu_grnt,
        output bmu_lsu_trans_cmplt,
        output bmu_lsu_data_vld,
        output bmu_lsu_acc_err
    );
endinterface

// File: rtl/cr_lsu_outstd_queue.sv
// In-order tracking queue for outstanding bus transactions: entries, head/tail
// pointers, occupancy counter and flush kill marking.
module cr_lsu_outstd_queue
    import cr_lsu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             sm_clk,
    input  logic             cpurst_b,
    input  logic             push,
    input  logic             push_store,
    input  logic             push_fast,
    input  logic             pop,
    input  logic             flush,
    output lsu_entry_t       head_entry,
    output logic [CNT_W-1:0] cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    lsu_entry_t       ent_q [DEPTH];
    lsu_entry_t       ent_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        ent_d  = ent_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_q[i].vld) ent_d[i].kill = 1'b1;
            end
        end
        if (pop) begin
            ent_d[head_q].vld = 1'b0;
            head_d            = ptr_inc(head_q);
        end
        // A grant in the flush cycle belongs to a flushed instruction, so it enters pre-killed.
        if (push) begin
            ent_d[tail_q] = '{vld: 1'b1, store: push_store, fast: push_fast, kill: flush};
            tail_d        = ptr_inc(tail_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: the entry array is reset too: it is tiny, and a stale vld/kill bit
    // after reset would leak into the first completion.
    always_ff @(posedge sm_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            ent_q  <= ent_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head_entry = ent_q[head_q];
    assign cnt        = cnt_q;

endmodule

// File: rtl/cr_lsu_ctrl_mo.sv
// LSU request controller with up to OUTSTD_DEPTH in-order outstanding bus
// transactions; stores may retire at grant, loads stall EX until completion.
module cr_lsu_ctrl_mo
    import cr_lsu_pkg::*;
#(
    parameter int OUTSTD_DEPTH = 2,
    parameter int CNT_W        = $clog2(OUTSTD_DEPTH + 1),
    parameter bit FAST_ST_EN   = 1'b1
) (
    input  logic             sm_clk,
    input  logic             cpurst_b,
    input  logic             iu_yy_xx_flush,
    input  logic             iu_lsu_ex_sel,
    input  logic             iu_lsu_ex_data_sel,
    input  logic             iu_lsu_ex_store,
    input  logic             iu_lsu_stall_without_hready,
    input  logic             dp_ctrl_misalign,
    input  logic             unalign_xx_split_on,
    cr_lsu_ctrl_mo_if.master bmu,
    output logic             lsu_iu_req,
    output logic             lsu_iu_fast_retire,
    output logic             lsu_iu_stall,
    output logic             lsu_iu_data_vld,
    output logic             lsu_iu_expt_vld,
    output logic [4:0]       lsu_iu_expt_vec,
    output logic             lsu_iu_wb_acc_err,
    output logic             lsu_iu_wfd,
    output logic             lsu_bmu_idle,
    output logic             ctrl_top_req_en,
    output logic [CNT_W-1:0] ctrl_outstd_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUTSTD_DEPTH - 1);

    lsu_state_e       state_q, state_d;
    logic             load_pending_q, load_pending_d;
    lsu_entry_t       head;
    logic [CNT_W-1:0] cnt;
    logic             bus_req, push, pop, push_fast;
    logic             head_live, head_done, cmplt_retire, misalign_retire, fast_retire;

    // No full bypass: a completion in a FULL cycle only frees the slot next cycle.
    assign bus_req   = iu_lsu_ex_data_sel & ~dp_ctrl_misalign & ~iu_lsu_stall_without_hready
                     & (state_q != ST_FULL) & ~load_pending_q;
    assign push      = bus_req & bmu.bmu_lsu_grnt;
    assign pop       = bmu.bmu_lsu_trans_cmplt;
    assign push_fast = FAST_ST_EN & iu_lsu_ex_store & ~unalign_xx_split_on;

    // A pending non-fast op blocks further issue, so it is always the youngest entry.
    assign head_done = load_pending_q & pop & (cnt == CNT_ONE);

    cr_lsu_outstd_queue #(
        .DEPTH (OUTSTD_DEPTH),
        .CNT_W (CNT_W)
    ) u_queue (
        .sm_clk     (sm_clk),
        .cpurst_b   (cpurst_b),
        .push       (push),
        .push_store (iu_lsu_ex_store),
        .push_fast  (push_fast),
        .pop        (pop),
        .flush      (iu_yy_xx_flush),
        .head_entry (head),
        .cnt        (cnt)
    );

    always_ff @(posedge sm_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q        <= ST_IDLE;
            load_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            load_pending_q <= load_pending_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (push && !pop) begin
            state_d = (cnt == CNT_LAST) ? ST_FULL : ST_ACTIVE;
        end else if (pop && !push) begin
            state_d = (cnt == CNT_ONE) ? ST_IDLE : ST_ACTIVE;
        end

        load_pending_d = load_pending_q;
        if (push && !push_fast) load_pending_d = 1'b1;
        if (head_done || iu_yy_xx_flush) load_pending_d = 1'b0;
    end

    always_comb begin
        head_live       = pop & head.vld & ~head.kill;
        cmplt_retire    = head_live & ~head.fast;
        misalign_retire = iu_lsu_ex_sel & dp_ctrl_misalign & ~load_pending_q;
        fast_retire     = push & push_fast & ~iu_yy_xx_flush;

        bmu.lsu_bmu_req    = bus_req;
        lsu_iu_req         = fast_retire | misalign_retire | cmplt_retire;
        lsu_iu_fast_retire = fast_retire;
        lsu_iu_data_vld    = cmplt_retire & bmu.bmu_lsu_data_vld & ~bmu.bmu_lsu_acc_err;
        lsu_iu_expt_vld    = misalign_retire | (cmplt_retire & bmu.bmu_lsu_acc_err);
        lsu_iu_wb_acc_err  = head_live & head.fast & bmu.bmu_lsu_acc_err;

        lsu_iu_expt_vec = '0;
        if (misalign_retire) begin
            lsu_iu_expt_vec = iu_lsu_ex_store ? EXPT_MISS : EXPT_MISL;
        end else if (cmplt_retire && bmu.bmu_lsu_acc_err) begin
            lsu_iu_expt_vec = head.store ? EXPT_ACCS : EXPT_ACCL;
        end

        lsu_iu_stall    = (iu_lsu_ex_sel & ~lsu_iu_req) | (load_pending_q & ~head_done);
        lsu_iu_wfd      = (cnt != '0);
        lsu_bmu_idle    = (cnt == '0) | ((cnt == CNT_ONE) & pop);
        ctrl_top_req_en = bus_req | (cnt != '0);
        ctrl_outstd_cnt = cnt;
    end

endmodule

// File: tb/tb_cr_lsu_ctrl_mo.sv
// Directed self-checking bench for cr_lsu_ctrl_mo with OUTSTD_DEPTH=2.
module tb_cr_lsu_ctrl_mo;

    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             sm_clk = 1'b0;
    logic             cpurst_b;
    logic             iu_yy_xx_flush, iu_lsu_ex_sel, iu_lsu_ex_data_sel, iu_lsu_ex_store;
    logic             iu_lsu_stall_without_hready, dp_ctrl_misalign, unalign_xx_split_on;
    logic             lsu_iu_req, lsu_iu_fast_retire, lsu_iu_stall, lsu_iu_data_vld;
    logic             lsu_iu_expt_vld, lsu_iu_wb_acc_err, lsu_iu_wfd, lsu_bmu_idle, ctrl_top_req_en;
    logic [4:0]       lsu_iu_expt_vec;
    logic [CNT_W-1:0] ctrl_outstd_cnt;

    int checks   = 0;
    int failures = 0;

    cr_lsu_ctrl_mo_if bmu_if ();

    cr_lsu_ctrl_mo #(.OUTSTD_DEPTH(DEPTH), .FAST_ST_EN(1'b1)) dut (
        .sm_clk                      (sm_clk),
        .cpurst_b                    (cpurst_b),
        .iu_yy_xx_flush              (iu_yy_xx_flush),
        .iu_lsu_ex_sel               (iu_lsu_ex_sel),
        .iu_lsu_ex_data_sel          (iu_lsu_ex_data_sel),
        .iu_lsu_ex_store             (iu_lsu_ex_store),
        .iu_lsu_stall_without_hready (iu_lsu_stall_without_hready),
        .dp_ctrl_misalign            (dp_ctrl_misalign),
        .unalign_xx_split_on         (unalign_xx_split_on),
        .bmu                         (bmu_if.master),
        .lsu_iu_req                  (lsu_iu_req),
        .lsu_iu_fast_retire          (lsu_iu_fast_retire),
        .lsu_iu_stall                (lsu_iu_stall),
        .lsu_iu_data_vld             (lsu_iu_data_vld),
        .lsu_iu_expt_vld             (lsu_iu_expt_vld),
        .lsu_iu_expt_vec             (lsu_iu_expt_vec),
        .lsu_iu_wb_acc_err           (lsu_iu_wb_acc_err),
        .lsu_iu_wfd                  (lsu_iu_wfd),
        .lsu_bmu_idle                (lsu_bmu_idle),
        .ctrl_top_req_en             (ctrl_top_req_en),
        .ctrl_outstd_cnt             (ctrl_outstd_cnt)
    );

    always #5 sm_clk = ~sm_clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ex(input logic sel, input logic dsel, input logic st, input logic mis);
        iu_lsu_ex_sel      = sel;
        iu_lsu_ex_data_sel = dsel;
        iu_lsu_ex_store    = st;
        dp_ctrl_misalign   = mis;
    endtask

    task automatic bus(input logic g, input logic c, input logic dv, input logic e);
        bmu_if.bmu_lsu_grnt        = g;
        bmu_if.bmu_lsu_trans_cmplt = c;
        bmu_if.bmu_lsu_data_vld    = dv;
        bmu_if.bmu_lsu_acc_err     = e;
    endtask

    task automatic settle();
        @(negedge sm_clk);
    endtask

    // Protocol invariants, checked once per cycle before the clock edge.
    task automatic adv();
        checks++;
        assert (!(bmu_if.bmu_lsu_trans_cmplt && ctrl_outstd_cnt == 0)) else begin
            failures++;
            $error("FAIL cmplt_when_empty observed=%0d expected=nonzero", ctrl_outstd_cnt);
        end
        checks++;
        assert (!(bmu_if.lsu_bmu_req && bmu_if.bmu_lsu_grnt && ctrl_outstd_cnt == DEPTH)) else begin
            failures++;
            $error("FAIL push_when_full observed=%0d expected=below_%0d", ctrl_outstd_cnt, DEPTH);
        end
        checks++;
        assert (ctrl_outstd_cnt <= DEPTH) else begin
            failures++;
            $error("FAIL cnt_overflow observed=%0d expected=max_%0d", ctrl_outstd_cnt, DEPTH);
        end
        @(posedge sm_clk);
        #1;
    endtask

    initial begin
        cpurst_b = 1'b0;
        iu_yy_xx_flush = 1'b0;
        iu_lsu_stall_without_hready = 1'b0;
        unalign_xx_split_on = 1'b0;
        ex(0, 0, 0, 0);
        bus(0, 0, 0, 0);
        settle();
        check("rst_cnt", 8'(ctrl_outstd_cnt), 8'd0);
        check("rst_idle", 8'(lsu_bmu_idle), 8'd1);
        check("rst_wfd", 8'(lsu_iu_wfd), 8'd0);
        check("rst_iu_req", 8'(lsu_iu_req), 8'd0);
        check("rst_bmu_req", 8'(bmu_if.lsu_bmu_req), 8'd0);
        check("rst_req_en", 8'(ctrl_top_req_en), 8'd0);
        @(posedge sm_clk);
        #2 cpurst_b = 1'b1;
        @(posedge sm_clk);
        #1;

        // Three back-to-back stores into a depth-2 queue.
        ex(1, 1, 1, 0);
        bus(1, 0, 0, 0);
        settle();
        check("t1_s1_bmu_req", 8'(bmu_if.lsu_bmu_req), 8'd1);
        check("t1_s1_iu_req", 8'(lsu_iu_req), 8'd1);
        check("t1_s1_fast", 8'(lsu_iu_fast_retire), 8'd1);
        check("t1_s1_stall", 8'(lsu_iu_stall), 8'd0);
        check("t1_s1_req_en", 8'(ctrl_top_req_en), 8'd1);
        adv();
        settle();
        check("t1_s2_cnt", 8'(ctrl_outstd_cnt), 8'd1);
        check("t1_s2_fast", 8'(lsu_iu_fast_retire), 8'd1);
        check("t1_s2_wfd", 8'(lsu_iu_wfd), 8'd1);
        adv();
        settle();
        check("t1_full_cnt", 8'(ctrl_outstd_cnt), 8'd2);
        check("t1_full_bmu_req", 8'(bmu_if.lsu_bmu_req), 8'd0);
        check("t1_full_iu_req", 8'(lsu_iu_req), 8'd0);
        check("t1_full_stall", 8'(lsu_iu_stall), 8'd1);
        adv();
        bus(1, 1, 0, 0);
        settle();
        check("t1_nobypass_bmu_req", 8'(bmu_if.lsu_bmu_req), 8'd0);
        check("t1_nobypass_idle", 8'(lsu_bmu_idle), 8'd0);
        check("t1_nobypass_wb_err", 8'(lsu_iu_wb_acc_err), 8'd0);
        adv();
        bus(1, 0, 0, 0);
        settle();
        check("t1_s3_cnt", 8'(ctrl_outstd_cnt), 8'd1);
        check("t1_s3_bmu_req", 8'(bmu_if.lsu_bmu_req), 8'd1);
        check("t1_s3_fast", 8'(lsu_iu_fast_retire), 8'd1);
        check("t1_s3_stall", 8'(lsu_iu_stall), 8'd0);
        adv();
        ex(0, 0, 0, 0);
        bus(0, 1, 0, 0);
        settle();
        check("t1_drain_cnt2", 8'(ctrl_outstd_cnt), 8'd2);
        adv();
        settle();
        check("t1_drain_cnt1", 8'(ctrl_outstd_cnt), 8'd1);
        check("t1_drain_idle", 8'(lsu_bmu_idle), 8'd1);
        check("t1_drain_wfd", 8'(lsu_iu_wfd), 8'd1);
        adv();
        bus(0, 0, 0, 0);
        settle();
        check("t1_empty_cnt", 8'(ctrl_outstd_cnt), 8'd0);
        check("t1_empty_wfd", 8'(lsu_iu_wfd), 8'd0);
        adv();

        // Store then load; the load stalls EX through both completions.
        ex(1, 1, 1, 0);
        bus(1, 0, 0, 0);
        settle();
        check("t2_st_fast", 8'(lsu_iu_fast_retire), 8'd1);
        adv();
        ex(1, 1, 0, 0);
        settle();
        check("t2_ld_bmu_req", 8'(bmu_if.lsu_bmu_req), 8'd1);
        check("t2_ld_iu_req", 8'(lsu_iu_req), 8'd0);
        check("t2_ld_fast", 8'(lsu_iu_fast_retire), 8'd0);
        check("t2_ld_stall", 8'(lsu_iu_stall), 8'd1);
        adv();
        bus(1, 1, 0, 0);
        settle();
        check("t2_c1_bmu_req", 8'(bmu_if.lsu_bmu_req), 8'd0);
        check("t2_c1_iu_req", 8'(lsu_iu_req), 8'd0);
        check("t2_c1_data_vld", 8'(lsu_iu_data_vld), 8'd0);
        check("t2_c1_stall", 8'(lsu_iu_stall), 8'd1);
        adv();
        bus(1, 1, 1, 0);
        settle();
        check("t2_c2_bmu_req_blocked", 8'(bmu_if.lsu_bmu_req), 8'd0);
        check("t2_c2_iu_req", 8'(lsu_iu_req), 8'd1);
        check("t2_c2_data_vld", 8'(lsu_iu_data_vld), 8'd1);
        check("t2_c2_stall", 8'(lsu_iu_stall), 8'd0);
        check("t2_c2_expt", 8'(lsu_iu_expt_vld), 8'd0);
        adv();
        ex(0, 0, 0, 0);
        bus(0, 0, 0, 0);
        settle();
        check("t2_end_cnt", 8'(ctrl_outstd_cnt), 8'd0);
        check("t2_end_stall", 8'(lsu_iu_stall), 8'd0);
        adv();

        // Load completing with an access error.
        ex(1, 1, 0, 0);
        bus(1, 0, 0, 0);
        settle();
        check("t3_ld_stall", 8'(lsu_iu_stall), 8'd1);
        adv();
        bus(0, 1, 1, 1);
        settle();
        check("t3_expt_vld", 8'(lsu_iu_expt_vld), 8'd1);
        check("t3_expt_vec", 8'(lsu_iu_expt_vec), 8'b00101);
        check("t3_data_vld", 8'(lsu_iu_data_vld), 8'd0);
        check("t3_iu_req", 8'(lsu_iu_req), 8'd1);
        check("t3_stall", 8'(lsu_iu_stall), 8'd0);
        adv();
        ex(0, 0, 0, 0);
        bus(0, 0, 0, 0);

        // Fast store completing with an access error gives only the imprecise pulse.
        ex(1, 1, 1, 0);
        bus(1, 0, 0, 0);
        settle();
        adv();
        ex(0, 0, 0, 0);
        bus(0, 1, 0, 1);
        settle();
        check("t3b_wb_acc_err", 8'(lsu_iu_wb_acc_err), 8'd1);
        check("t3b_expt", 8'(lsu_iu_expt_vld), 8'd0);
        check("t3b_iu_req", 8'(lsu_iu_req), 8'd0);
        adv();
        bus(0, 0, 0, 0);

        // Two stores outstanding, then a flush kills both.
        ex(1, 1, 1, 0);
        bus(1, 0, 0, 0);
        settle();
        adv();
        settle();
        adv();
        ex(0, 0, 0, 0);
        bus(0, 0, 0, 0);
        iu_yy_xx_flush = 1'b1;
        settle();
        check("t4_flush_cnt", 8'(ctrl_outstd_cnt), 8'd2);
        adv();
        iu_yy_xx_flush = 1'b0;
        bus(0, 1, 0, 0);
        settle();
        check("t4_c1_cnt", 8'(ctrl_outstd_cnt), 8'd2);
        check("t4_c1_wb_err", 8'(lsu_iu_wb_acc_err), 8'd0);
        adv();
        bus(0, 1, 0, 1);
        settle();
        check("t4_c2_cnt", 8'(ctrl_outstd_cnt), 8'd1);
        check("t4_c2_wb_err", 8'(lsu_iu_wb_acc_err), 8'd0);
        check("t4_c2_iu_req", 8'(lsu_iu_req), 8'd0);
        check("t4_c2_expt", 8'(lsu_iu_expt_vld), 8'd0);
        check("t4_c2_idle", 8'(lsu_bmu_idle), 8'd1);
        adv();
        bus(0, 0, 0, 0);
        settle();
        check("t4_end_cnt", 8'(ctrl_outstd_cnt), 8'd0);
        check("t4_end_idle", 8'(lsu_bmu_idle), 8'd1);
        adv();

        // Store granted in the flush cycle is pushed already killed.
        ex(1, 1, 1, 0);
        bus(1, 0, 0, 0);
        iu_yy_xx_flush = 1'b1;
        settle();
        check("t4b_bmu_req", 8'(bmu_if.lsu_bmu_req), 8'd1);
        adv();
        iu_yy_xx_flush = 1'b0;
        ex(0, 0, 0, 0);
        bus(0, 1, 0, 1);
        settle();
        check("t4b_cnt", 8'(ctrl_outstd_cnt), 8'd1);
        check("t4b_wb_err", 8'(lsu_iu_wb_acc_err), 8'd0);
        adv();
        bus(0, 0, 0, 0);

        // Misaligned store and load in EX.
        ex(1, 1, 1, 1);
        bus(1, 0, 0, 0);
        settle();
        check("t5_st_bmu_req", 8'(bmu_if.lsu_bmu_req), 8'd0);
        check("t5_st_expt", 8'(lsu_iu_expt_vld), 8'd1);
        check("t5_st_vec", 8'(lsu_iu_expt_vec), 8'b00110);
        check("t5_st_iu_req", 8'(lsu_iu_req), 8'd1);
        check("t5_st_stall", 8'(lsu_iu_stall), 8'd0);
        adv();
        ex(1, 1, 0, 1);
        settle();
        check("t5_st_cnt", 8'(ctrl_outstd_cnt), 8'd0);
        check("t5_ld_expt", 8'(lsu_iu_expt_vld), 8'd1);
        check("t5_ld_vec", 8'(lsu_iu_expt_vec), 8'b00100);
        adv();

        // Reset asserted with two transactions outstanding.
        ex(1, 1, 1, 0);
        bus(1, 0, 0, 0);
        settle();
        adv();
        settle();
        adv();
        ex(0, 0, 0, 0);
        bus(0, 0, 0, 0);
        #1 check("t6_pre_cnt", 8'(ctrl_outstd_cnt), 8'd2);
        cpurst_b = 1'b0;
        #1;
        check("t6_rst_cnt", 8'(ctrl_outstd_cnt), 8'd0);
        check("t6_rst_idle", 8'(lsu_bmu_idle), 8'd1);
        check("t6_rst_wfd", 8'(lsu_iu_wfd), 8'd0);
        check("t6_rst_req_en", 8'(ctrl_top_req_en), 8'd0);
        check("t6_rst_stall", 8'(lsu_iu_stall), 8'd0);
        #1 cpurst_b = 1'b1;
        settle();
        check("t6_post_cnt", 8'(ctrl_outstd_cnt), 8'd0);
        adv();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cr_lsu_ctrl_mo.md
Name: cr_lsu_ctrl_mo

Overview:
- Parametrised successor to the single-outstanding LSU request controller; sits between IU EX/WB control and the BMU data-bus port.
- Allows up to OUTSTD_DEPTH in-order outstanding bus transactions through a head/tail tracking queue.
- Stores fast-retire at grant. A load stalls EX until its own completion. Exceptions and flush kills are tracked per entry.
- Control only; address and data stay in the LSU datapath.

Parameters:
- OUTSTD_DEPTH, 2: max outstanding transactions; legal 1..8. 1 gives single-outstanding behaviour.
- CNT_W, $clog2(OUTSTD_DEPTH+1): occupancy counter width (derived).
- FAST_ST_EN, 1: 1 = non-split stores retire at grant; 0 = every transaction retires at completion.

Ports:
- sm_clk  in  1  clock
- cpurst_b  in  1  asynchronous active-low reset
- iu_yy_xx_flush  in  1  pipeline flush
- iu_lsu_ex_sel  in  1  ld/st in EX requesting retire
- iu_lsu_ex_data_sel  in  1  ld/st in EX, early qualifier
- iu_lsu_ex_store  in  1  EX op is store
- iu_lsu_stall_without_hready  in  1  IU stall excluding bus ready
- dp_ctrl_misalign  in  1  EX address misaligned
- unalign_xx_split_on  in  1  split access in progress (disables fast retire)
- bmu_lsu_grnt  in  1  bus accepted request
- bmu_lsu_trans_cmplt  in  1  head transaction complete
- bmu_lsu_data_vld  in  1  load data valid with completion
- bmu_lsu_acc_err  in  1  access error with completion
- lsu_bmu_req  out  1  bus request
- lsu_iu_req  out  1  EX retire request
- lsu_iu_fast_retire  out  1  retire occurs at grant
- lsu_iu_stall  out  1  stall EX
- lsu_iu_data_vld  out  1  load data to WB
- lsu_iu_expt_vld  out  1  precise exception
- lsu_iu_expt_vec  out  5  exception vector
- lsu_iu_wb_acc_err  out  1  imprecise error on a fast-retired store
- lsu_iu_wfd  out  1  any entry outstanding
- lsu_bmu_idle  out  1  no live entry outstanding
- ctrl_top_req_en  out  1  clock-gate enable
- ctrl_outstd_cnt  out  CNT_W  occupancy

Behaviour:
- Reset (async, cpurst_b=0): queue empty, cnt=0, state IDLE. All pulse outputs are 0; lsu_bmu_idle=1; lsu_iu_wfd=0.
- Entry fields: {vld, store, fast, kill}. Head and tail are mod-OUTSTD_DEPTH pointers.
- State machine on occupancy:
  - IDLE: cnt==0.
  - ACTIVE: 0<cnt<DEPTH.
  - FULL: cnt==DEPTH.
  - Transitions follow push/pop in the same cycle. Push and pop together keep cnt and state unchanged.
- Issue: lsu_bmu_req = ex_data_sel & !misalign & !stall_without_hready & state!=FULL & !load_pending.
  - No full bypass: a completion in a FULL cycle does not enable issue in that cycle.
- Push on lsu_bmu_req & grnt. fast = FAST_ST_EN & store & !split_on.
- Fast retire: lsu_iu_req = lsu_iu_fast_retire = 1 in the grant cycle, zero latency.
- Load (or non-fast op):
  - load_pending is set at grant.
  - lsu_iu_stall stays high until that entry reaches head and completes.
  - lsu_iu_req pulses in the completion cycle, with lsu_iu_data_vld = data_vld & !acc_err.
- Misalign: lsu_iu_req=1 and lsu_iu_expt_vld=1 in the EX cycle; no push.
  - Vector: 00100 for a load, 00110 for a store.
- Completion pops the head.
  - acc_err on a non-fast, unkilled entry: expt_vld=1, vec 00101 (load) or 00111 (store), no data_vld.
  - acc_err on a fast entry: lsu_iu_wb_acc_err pulse only.
- lsu_iu_stall = ex_sel & !(retire this cycle) | load_pending & !(head completes this cycle).
- Flush:
  - Sets kill on all valid entries and clears load_pending.
  - cnt is NOT reset; the bus cannot abort.
  - A killed completion pops silently: no req, data_vld, expt or wb_acc_err.
  - A grant in the flush cycle is pushed already killed.
- lsu_bmu_idle = (cnt==0) | (cnt==1 & trans_cmplt). lsu_iu_wfd = cnt!=0.
- ctrl_top_req_en = lsu_bmu_req | cnt!=0.
- Assertions (cover in the bench):
  - No completion when empty.
  - No push when FULL.
  - cnt never exceeds DEPTH.

Decomposition:
- Shared package cr_lsu_pkg: exception vectors MISL/MISS/ACCL/ACCS, state encodings, entry struct.
- One sub-module: cr_lsu_outstd_queue, holding entry storage, pointers, counter and kill marking.

Test Plan:
- Three back-to-back granted stores, DEPTH=2 -> stores 1 and 2 fast-retire in their grant cycles; cnt reaches 2 (FULL); store 3 req=0 until first cmplt, then issues the next cycle.
- Store granted, then load granted, then cmplt, cmplt+data_vld -> stall holds through both completions; lsu_iu_req and data_vld pulse only on the second completion.
- Load completes with acc_err -> expt_vld=1, vec=00101, data_vld=0, stall drops the same cycle.
- Two stores outstanding, flush, then two cmplts (second with acc_err) -> no wb_acc_err; cnt goes 2→1→0; idle=1 after.
- Misaligned store in EX -> expt_vld=1, vec=00110, lsu_bmu_req=0, cnt unchanged.
- Reset asserted with cnt=2 mid-transfer -> all outputs return to reset values immediately; cnt=0.
